multi_channel_word_builder: RTL and testbench

// Successor to the single-channel FE-I4 receiver word path. Takes CHANNELS streams of decoded 8b10b

---
 rtl/multi_channel_word_builder.sv | 189 ++++++++++++++++++
 tb/tb_multi_channel_word_builder.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_word_builder.sv
// Assembles per-channel 8b10b data bytes into words, buffers each channel in a small FIFO and
// merges the channels round-robin onto one valid/ready stream tagged with the source channel.
module multi_channel_word_builder #(
  parameter int CHANNELS       = 4,
  parameter int BYTES_PER_WORD = 3,
  parameter int FIFO_DEPTH     = 8,
  parameter int CNT_WIDTH      = 8,
  localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int DW            = 8 * BYTES_PER_WORD
) (
  input  logic                          WCLK,
  input  logic                          RESET_N,
  input  logic                          SOFT_RST,
  input  logic [CHANNELS-1:0]           CH_EN,
  input  logic [CHANNELS-1:0]           SYM_VALID,
  input  logic [CHANNELS-1:0]           SYM_K,
  input  logic [8*CHANNELS-1:0]         SYM_DATA,
  input  logic [CHANNELS-1:0]           SYM_ERR,
  output logic                          OUT_VALID,
  input  logic                          OUT_READY,
  output logic [DW-1:0]                 OUT_DATA,
  output logic [CH_W-1:0]               OUT_CH,
  output logic [CHANNELS-1:0]           FIFO_FULL,
  output logic [CNT_WIDTH*CHANNELS-1:0] LOST_ERR_CNT,
  output logic [CNT_WIDTH*CHANNELS-1:0] DECODER_ERR_CNT
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int SEL_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  logic [DW-1:0]       head [CHANNELS];
  logic [CHANNELS-1:0] not_empty;
  logic [CHANNELS-1:0] pop;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [SEL_W-1:0]     byte_sel_q, byte_sel_d;
    logic [DW-1:0]        word_q, word_d;
    logic                 push_q, push_d;
    logic [CNT_WIDTH-1:0] dec_cnt_q, dec_cnt_d;
    logic [CNT_WIDTH-1:0] lost_cnt_q, lost_cnt_d;
    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic [DW-1:0]        mem_q [FIFO_DEPTH];
    logic                 full;
    logic                 wr_en;
    logic [7:0]           sym_byte;

    assign sym_byte = SYM_DATA[8*gi +: 8];
    // Full comes from the pointers alone, so a same-cycle pop never rescues an incoming word.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign wr_en = push_q && !full;

    always_comb begin
      byte_sel_d = byte_sel_q;
      word_d     = word_q;
      push_d     = 1'b0;
      dec_cnt_d  = dec_cnt_q;
      lost_cnt_d = lost_cnt_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (!CH_EN[gi]) begin
        byte_sel_d = '0;
      end else if (SYM_VALID[gi]) begin
        if (SYM_ERR[gi]) begin
          byte_sel_d = '0;
          if (dec_cnt_q != '1) dec_cnt_d = dec_cnt_q + CNT_WIDTH'(1);
        end else if (SYM_K[gi]) begin
          byte_sel_d = '0;
        end else begin
          for (int b = 0; b < BYTES_PER_WORD; b++) begin
            if (byte_sel_q == SEL_W'(b)) word_d[DW-1-8*b -: 8] = sym_byte;
          end
          if (byte_sel_q == SEL_W'(BYTES_PER_WORD - 1)) begin
            byte_sel_d = '0;
            push_d     = 1'b1;
          end else begin
            byte_sel_d = byte_sel_q + SEL_W'(1);
          end
        end
      end
      if (push_q && full && (lost_cnt_q != '1)) lost_cnt_d = lost_cnt_q + CNT_WIDTH'(1);
      if (wr_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop[gi]) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      if (SOFT_RST) begin
        byte_sel_d = '0;
        word_d     = '0;
        push_d     = 1'b0;
        dec_cnt_d  = '0;
        lost_cnt_d = '0;
        wr_ptr_d   = '0;
        rd_ptr_d   = '0;
      end
    end

    always_ff @(posedge WCLK or negedge RESET_N) begin
      if (!RESET_N) begin
        byte_sel_q <= '0;
        word_q     <= '0;
        push_q     <= 1'b0;
        dec_cnt_q  <= '0;
        lost_cnt_q <= '0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
      end else begin
        byte_sel_q <= byte_sel_d;
        word_q     <= word_d;
        push_q     <= push_d;
        dec_cnt_q  <= dec_cnt_d;
        lost_cnt_q <= lost_cnt_d;
        wr_ptr_q   <= wr_ptr_d;
        rd_ptr_q   <= rd_ptr_d;
      end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge WCLK) begin
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= word_q;
    end

    assign head[gi]      = mem_q[rd_ptr_q[AW-1:0]];
    assign not_empty[gi] = (wr_ptr_q != rd_ptr_q);
    assign FIFO_FULL[gi] = full;
    assign LOST_ERR_CNT[CNT_WIDTH*gi +: CNT_WIDTH]    = lost_cnt_q;
    assign DECODER_ERR_CNT[CNT_WIDTH*gi +: CNT_WIDTH] = dec_cnt_q;
  end

  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [CH_W-1:0] out_ch_q, out_ch_d;
  logic [CH_W-1:0] rr_q, rr_d;
  logic            grant_found;
  logic [CH_W-1:0] grant;
  int              idx;

  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    idx         = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = (int'(rr_q) + i) % CHANNELS;
      if (!grant_found && not_empty[CH_W'(idx)]) begin
        grant_found = 1'b1;
        grant       = CH_W'(idx);
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_d        = rr_q;
    pop         = '0;
    if (!out_valid_q || OUT_READY) begin
      out_valid_d = grant_found;
      if (grant_found) begin
        out_data_d  = head[grant];
        out_ch_d    = grant;
        pop[grant]  = 1'b1;
        rr_d        = (grant == CH_W'(CHANNELS - 1)) ? '0 : grant + CH_W'(1);
      end
    end
    if (SOFT_RST) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_ch_d    = '0;
      rr_d        = '0;
    end
  end

  always_ff @(posedge WCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_q        <= rr_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_CH    = out_ch_q;

endmodule

// File: tb/tb_multi_channel_word_builder.sv
// Randomized and directed checks of multi_channel_word_builder against a queue-based model.
module tb_multi_channel_word_builder;

  localparam int CH    = 4;
  localparam int BPW   = 3;
  localparam int DEPTH = 8;
  localparam int CW    = 8;
  localparam int DW    = 8 * BPW;
  localparam int CHW   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              soft_rst;
  logic [CH-1:0]     ch_en, sym_valid, sym_k, sym_err;
  logic [8*CH-1:0]   sym_data;
  logic              out_valid, out_ready;
  logic [DW-1:0]     out_data;
  logic [CHW-1:0]    out_ch;
  logic [CH-1:0]     fifo_full;
  logic [CW*CH-1:0]  lost_cnt, dec_cnt;

  multi_channel_word_builder #(
    .CHANNELS(CH), .BYTES_PER_WORD(BPW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .WCLK(clk), .RESET_N(rst_n), .SOFT_RST(soft_rst), .CH_EN(ch_en),
    .SYM_VALID(sym_valid), .SYM_K(sym_k), .SYM_DATA(sym_data), .SYM_ERR(sym_err),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data), .OUT_CH(out_ch),
    .FIFO_FULL(fifo_full), .LOST_ERR_CNT(lost_cnt), .DECODER_ERR_CNT(dec_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: byte lists, word queues and plain counters.
  logic [DW-1:0] m_fifo [CH][$];
  byte unsigned  m_part [CH][$];
  bit            m_pend [CH];
  logic [DW-1:0] m_pend_w [CH];
  int            m_lost [CH];
  int            m_dec [CH];
  bit            m_valid;
  logic [DW-1:0] m_data;
  int            m_ch;
  int            m_rr;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_fifo[c].delete();
      m_part[c].delete();
      m_pend[c] = 1'b0;
      m_pend_w[c] = '0;
      m_lost[c] = 0;
      m_dec[c] = 0;
    end
    m_valid = 1'b0;
    m_data = '0;
    m_ch = 0;
    m_rr = 0;
  endtask

  task automatic model_step();
    bit was_full [CH];
    logic [DW-1:0] w;
    for (int c = 0; c < CH; c++) was_full[c] = (m_fifo[c].size() == DEPTH);
    if (!m_valid || out_ready) begin
      m_valid = 1'b0;
      for (int i = 0; i < CH; i++) begin
        int c;
        c = (m_rr + i) % CH;
        if (m_fifo[c].size() > 0) begin
          m_data = m_fifo[c].pop_front();
          m_ch = c;
          m_valid = 1'b1;
          m_rr = (c + 1) % CH;
          break;
        end
      end
    end
    for (int c = 0; c < CH; c++) begin
      if (m_pend[c]) begin
        if (was_full[c]) m_lost[c] = (m_lost[c] < 255) ? m_lost[c] + 1 : 255;
        else m_fifo[c].push_back(m_pend_w[c]);
      end
      m_pend[c] = 1'b0;
    end
    for (int c = 0; c < CH; c++) begin
      if (!ch_en[c]) begin
        m_part[c].delete();
      end else if (sym_valid[c]) begin
        if (sym_err[c]) begin
          m_dec[c] = (m_dec[c] < 255) ? m_dec[c] + 1 : 255;
          m_part[c].delete();
        end else if (sym_k[c]) begin
          m_part[c].delete();
        end else begin
          m_part[c].push_back(sym_data[8*c +: 8]);
          if (m_part[c].size() == BPW) begin
            w = '0;
            foreach (m_part[c][j]) w = (w << 8) | DW'(m_part[c][j]);
            m_pend[c] = 1'b1;
            m_pend_w[c] = w;
            m_part[c].delete();
          end
        end
      end
    end
  endtask

  function automatic logic [CW*CH-1:0] pack_cnt(input bit lost);
    logic [CW*CH-1:0] v;
    v = '0;
    for (int c = 0; c < CH; c++) v[CW*c +: CW] = CW'(lost ? m_lost[c] : m_dec[c]);
    return v;
  endfunction

  function automatic logic [CH-1:0] exp_full();
    logic [CH-1:0] v;
    for (int c = 0; c < CH; c++) v[c] = (m_fifo[c].size() == DEPTH);
    return v;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n || soft_rst) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        check("m_out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
          check("m_out_data", 64'(out_data), 64'(m_data));
          check("m_out_ch", 64'(out_ch), 64'(m_ch));
        end
        check("m_fifo_full", 64'(fifo_full), 64'(exp_full()));
        check("m_lost_cnt", 64'(lost_cnt), 64'(pack_cnt(1'b1)));
        check("m_dec_cnt", 64'(dec_cnt), 64'(pack_cnt(1'b0)));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int c, input bit k, input bit e, input logic [7:0] d);
    sym_valid = '0;
    sym_valid[c] = 1'b1;
    sym_k[c] = k;
    sym_err[c] = e;
    sym_data[8*c +: 8] = d;
    tick();
    sym_valid = '0;
    sym_k = '0;
    sym_err = '0;
  endtask

  function automatic logic [DW-1:0] all_word(input int r, input int c);
    logic [DW-1:0] w;
    w = '0;
    for (int j = 0; j < BPW; j++) w = (w << 8) | DW'(8'(r*64 + c*16 + j));
    return w;
  endfunction

  task automatic send_all(input int r);
    for (int j = 0; j < BPW; j++) begin
      sym_valid = '1;
      sym_k = '0;
      sym_err = '0;
      for (int c = 0; c < CH; c++) sym_data[8*c +: 8] = 8'(r*64 + c*16 + j);
      tick();
    end
    sym_valid = '0;
  endtask

  function automatic logic [DW-1:0] t4_word(input int w);
    return {8'(8'h40 + w), 8'(8'h80 + w), 8'(8'hC0 + w)};
  endfunction

  logic [DW-1:0] got_d[$];
  int            got_c[$];

  task automatic collect(input int cycles);
    got_d.delete();
    got_c.delete();
    for (int i = 0; i < cycles; i++) begin
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_c.push_back(int'(out_ch));
      end
      tick();
    end
  endtask

  task automatic wait_valid(input int max_cyc, input string name);
    int n;
    n = 0;
    while (!out_valid && n < max_cyc) begin
      tick();
      n++;
    end
    check(name, 64'(out_valid), 64'd1);
  endtask

  initial begin
    int seen;
    int bias;
    rst_n = 1'b0;
    soft_rst = 1'b0;
    ch_en = '1;
    sym_valid = '0;
    sym_k = '0;
    sym_err = '0;
    sym_data = '0;
    out_ready = 1'b1;
    tick();
    cmp_on = 1'b1;
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_fifo_full", 64'(fifo_full), 64'd0);
    check("rst_counters", 64'({lost_cnt, dec_cnt}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic word on ch0 with exact latency.
    send(0, 1'b1, 1'b0, 8'hBC);
    send(0, 1'b0, 1'b0, 8'hAA);
    send(0, 1'b0, 1'b0, 8'hBB);
    send(0, 1'b0, 1'b0, 8'hCC);
    check("t1_lat0", 64'(out_valid), 64'd0);
    tick();
    check("t1_lat1", 64'(out_valid), 64'd0);
    tick();
    check("t1_lat2_valid", 64'(out_valid), 64'd1);
    check("t1_data", 64'(out_data), 64'hAABBCC);
    check("t1_ch", 64'(out_ch), 64'd0);
    $display("t1: ch%0d word %06h", out_ch, out_data);
    tick();
    check("t1_drained", 64'(out_valid), 64'd0);

    // K in the middle discards the partial word.
    send(2, 1'b0, 1'b0, 8'hAA);
    send(2, 1'b0, 1'b0, 8'hBB);
    send(2, 1'b1, 1'b0, 8'h3C);
    send(2, 1'b0, 1'b0, 8'h11);
    send(2, 1'b0, 1'b0, 8'h22);
    send(2, 1'b0, 1'b0, 8'h33);
    collect(8);
    check("t2_count", 64'(got_d.size()), 64'd1);
    check("t2_data", 64'(got_d[0]), 64'h112233);
    check("t2_ch", 64'(got_c[0]), 64'd2);
    $display("t2: %0d word(s), first %06h from ch%0d", got_d.size(), got_d[0], got_c[0]);

    // Soft reset brings the pointer back to 0, then the round-robin order checks.
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    check("srst_out_valid", 64'(out_valid), 64'd0);
    send_all(0);
    tick();
    for (int i = 0; i < CH; i++) begin
      tick();
      check("t3a_valid", 64'(out_valid), 64'd1);
      check("t3a_ch", 64'(out_ch), 64'(i));
      check("t3a_data", 64'(out_data), 64'(all_word(0, i)));
      $display("t3a: ch%0d word %06h", out_ch, out_data);
    end
    send(0, 1'b0, 1'b0, 8'h01);
    send(0, 1'b0, 1'b0, 8'h02);
    send(0, 1'b0, 1'b0, 8'h03);
    wait_valid(6, "t3_single_timeout");
    tick();
    send_all(1);
    tick();
    for (int i = 0; i < CH; i++) begin
      tick();
      check("t3b_valid", 64'(out_valid), 64'd1);
      check("t3b_ch", 64'(out_ch), 64'((i + 1) % CH));
      check("t3b_data", 64'(out_data), 64'(all_word(1, (i + 1) % CH)));
      $display("t3b: ch%0d word %06h", out_ch, out_data);
    end
    tick();

    // Overflow of ch1 under backpressure.
    out_ready = 1'b0;
    for (int w = 0; w < DEPTH + 3; w++) begin
      logic [DW-1:0] tw;
      tw = t4_word(w);
      send(1, 1'b0, 1'b0, tw[23:16]);
      send(1, 1'b0, 1'b0, tw[15:8]);
      send(1, 1'b0, 1'b0, tw[7:0]);
    end
    tick();
    tick();
    check("t4_full1", 64'(fifo_full[1]), 64'd1);
    check("t4_lost1", 64'(lost_cnt[15:8]), 64'd2);
    check("t4_hold_data", 64'(out_data), 64'(t4_word(0)));
    out_ready = 1'b1;
    collect(20);
    check("t4_count", 64'(got_d.size()), 64'(DEPTH + 1));
    for (int i = 0; i < got_d.size() && i < DEPTH + 1; i++) begin
      check("t4_order", 64'(got_d[i]), 64'(t4_word(i)));
      check("t4_ch", 64'(got_c[i]), 64'd1);
    end
    $display("t4: %0d words out of ch1, lost %0d", got_d.size(), lost_cnt[15:8]);

    // Decoder-error saturation and disabled channels.
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      sym_valid[3] = 1'b1;
      sym_err[3] = 1'b1;
      sym_data[31:24] = 8'(i);
      tick();
      if (out_valid) seen++;
    end
    sym_valid = '0;
    sym_err = '0;
    check("t5_no_words", 64'(seen), 64'd0);
    check("t5_dec3", 64'(dec_cnt[31:24]), 64'hFF);
    ch_en[3] = 1'b0;
    ch_en[0] = 1'b0;
    send(3, 1'b0, 1'b1, 8'h00);
    send(3, 1'b0, 1'b0, 8'hAA);
    send(3, 1'b0, 1'b0, 8'hBB);
    send(3, 1'b0, 1'b0, 8'hCC);
    send(0, 1'b0, 1'b1, 8'h00);
    send(0, 1'b0, 1'b1, 8'h00);
    collect(6);
    check("t5_dis_words", 64'(got_d.size()), 64'd0);
    check("t5_dis_dec0", 64'(dec_cnt[7:0]), 64'd0);
    check("t5_dis_dec3", 64'(dec_cnt[31:24]), 64'hFF);
    $display("t5: dec ch3=%0h ch0=%0h", dec_cnt[31:24], dec_cnt[7:0]);
    ch_en = '1;

    // Asynchronous reset in the middle of a held transfer.
    out_ready = 1'b0;
    send(0, 1'b0, 1'b0, 8'hDE);
    send(0, 1'b0, 1'b0, 8'hAD);
    send(0, 1'b0, 1'b0, 8'hBE);
    wait_valid(6, "t6_pre_timeout");
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 64'(out_valid), 64'd0);
    check("t6_async_data", 64'(out_data), 64'd0);
    check("t6_async_cnt", 64'({lost_cnt, dec_cnt}), 64'd0);
    check("t6_async_full", 64'(fifo_full), 64'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    send(2, 1'b0, 1'b0, 8'h5A);
    send(2, 1'b0, 1'b0, 8'hA5);
    send(2, 1'b0, 1'b0, 8'h3C);
    wait_valid(6, "t6_post_timeout");
    check("t6_post_data", 64'(out_data), 64'h5AA53C);
    check("t6_post_ch", 64'(out_ch), 64'd2);
    $display("t6: after reset ch%0d word %06h", out_ch, out_data);

    // Random traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bias = ((cyc / 250) % 3 == 0) ? 95 : (((cyc / 250) % 3 == 1) ? 15 : 60);
      out_ready = ($urandom_range(0, 99) < bias);
      soft_rst = ($urandom_range(0, 999) < 3);
      for (int c = 0; c < CH; c++) begin
        ch_en[c] = ($urandom_range(0, 99) < 95);
        sym_valid[c] = ($urandom_range(0, 99) < 70);
        sym_k[c] = ($urandom_range(0, 99) < 8);
        sym_err[c] = ($urandom_range(0, 99) < 4);
        sym_data[8*c +: 8] = 8'($urandom);
      end
      tick();
    end
    sym_valid = '0;
    soft_rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    $display("random phase done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
